// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helper for the binary-to-BCD converter
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Smallest digit count whose decimal range covers every w_in-bit unsigned value.
  function automatic int min_digits(input int w_in);
    longint unsigned max_val;
    longint unsigned limit;
    int              digits;
    max_val = (64'd1 << w_in) - 64'd1;
    limit   = 64'd10;
    digits  = 1;
    for (int i = 0; i < 19; i++) begin
      if (limit <= max_val) begin
        digits = digits + 1;
        limit  = limit * 64'd10;
      end
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - per-digit add-3 adjust applied before each double-dabble shift
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Digits of 5..9 would become >=10 after doubling; pre-adding 3 makes the shift carry into the next digit.
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative shift-add-3 converter from unsigned binary to packed BCD
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W_IN   = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W_IN-1:0]               in_data,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(W_IN + 1);

  // Refuse to build a converter that cannot represent the largest input.
  if (DIGITS < min_digits(W_IN)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d too small for W_IN=%0d", DIGITS, W_IN);
  end

  state_t           state;
  logic [W_IN-1:0]  shift_bin;
  logic [BCD_W-1:0] shift_bcd;
  logic [BCD_W-1:0] adj_bcd;
  logic [BCD_W-1:0] next_bcd;
  logic [CNT_W-1:0] count;

  // One add-3 cell per digit, all acting on the current partial result.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit    (shift_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits shifted left, pulling in the next binary MSB.
  assign next_bcd = {adj_bcd[BCD_W-2:0], shift_bin[W_IN-1]};

  // Idle is the only state that accepts work; decoded purely from registered state.
  assign in_ready = (state == IDLE);

  // Conversion FSM: load on accept, shift W_IN times, publish result on the last shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_bin <= '0;
      shift_bcd <= '0;
      count     <= '0;
      out_bcd   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_bin <= in_data;
            shift_bcd <= '0;
            count     <= CNT_W'(W_IN);
            state     <= CONV;
          end
        end
        CONV: begin
          shift_bcd <= next_bcd;
          shift_bin <= {shift_bin[W_IN-2:0], 1'b0};
          count     <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            out_bcd <= next_bcd;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        done;
  logic [11:0] out_bcd;

  logic        in_valid_w;
  logic        in_ready_w;
  logic [9:0]  in_data_w;
  logic        done_w;
  logic [15:0] out_bcd_w;

  int checks;
  int failures;

  bin_to_bcd_seq #(.W_IN(8), .DIGITS(3)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .done     (done),
    .out_bcd  (out_bcd)
  );

  bin_to_bcd_seq #(.W_IN(10), .DIGITS(4)) u_dut_wide (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid_w),
    .in_ready (in_ready_w),
    .in_data  (in_data_w),
    .done     (done_w),
    .out_bcd  (out_bcd_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // Offer v, then count edges after acceptance until done; data lines carry noise meanwhile.
  task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      in_data = 8'($urandom);
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'd8);
    check_eq({tag, "_value"}, 32'(out_bcd), 32'(exp));
    check_eq({tag, "_ready_with_done"}, 32'(in_ready), 32'd1);
    tick();
    check_eq({tag, "_done_width"}, 32'(done), 32'd0);
    check_eq({tag, "_held"}, 32'(out_bcd), 32'(exp));
  endtask

  task automatic convert_wide(input string tag, input logic [9:0] v, input logic [15:0] exp);
    int n;
    in_valid_w = 1'b1;
    in_data_w  = v;
    tick();
    in_valid_w = 1'b0;
    n = 0;
    while (!done_w && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'd10);
    check_eq({tag, "_value"}, 32'(out_bcd_w), 32'(exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] r;
    int n;
    int seen_done;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_valid_w = 1'b0;
    in_data_w  = 10'h000;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_out", 32'(out_bcd), 32'h000);

    convert("v0",   8'd0,   12'h000);
    convert("v9",   8'd9,   12'h009);
    convert("v10",  8'd10,  12'h010);
    convert("v99",  8'd99,  12'h099);
    convert("v100", 8'd100, 12'h100);
    convert("v255", 8'd255, 12'h255);

    // Back-to-back with in_valid held: second value taken at E9, noise before it ignored.
    in_valid = 1'b1;
    in_data  = 8'd37;
    tick();
    for (int i = 1; i <= 8; i++) begin
      in_data = (i == 8) ? 8'd128 : 8'(200 + i);
      if (i < 8) check_eq("b2b_busy", 32'(in_ready), 32'd0);
      tick();
    end
    check_eq("b2b_first_done", 32'(done), 32'd1);
    check_eq("b2b_first_value", 32'(out_bcd), 32'h037);
    in_data = 8'd128;
    tick();
    check_eq("b2b_second_accepted", 32'(in_ready), 32'd0);
    check_eq("b2b_done_once", 32'(done), 32'd0);
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      in_data = 8'($urandom);
      tick();
      n++;
    end
    check_eq("b2b_second_latency", 32'(n), 32'd8);
    check_eq("b2b_second_value", 32'(out_bcd), 32'h128);
    tick();

    // Reset at E4 of a 200 conversion aborts it.
    in_valid = 1'b1;
    in_data  = 8'd200;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_out", 32'(out_bcd), 32'h000);
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    check_eq("abort_done", 32'(done), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen_done++;
      tick();
    end
    check_eq("abort_no_late_done", 32'(seen_done), 32'd0);
    convert("v45", 8'd45, 12'h045);

    // Reset beats a simultaneous valid.
    in_valid = 1'b1;
    in_data  = 8'd77;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check_eq("rst_wins_ready", 32'(in_ready), 32'd1);
    check_eq("rst_wins_out", 32'(out_bcd), 32'h000);

    // Output hold while idle with noisy data.
    convert("v173", 8'd173, 12'h173);
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i * 37 + 5);
      tick();
      check_eq("hold_out", 32'(out_bcd), 32'h173);
      check_eq("hold_done", 32'(done), 32'd0);
    end

    // Exhaustive sweep against an arithmetic reference.
    for (int v = 0; v < 256; v++) begin
      in_valid = 1'b1;
      in_data  = 8'(v);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      r = ref_bcd(v);
      if (out_bcd !== r || n != 8) check_eq("sweep_value", 32'(out_bcd), 32'(r));
      if (out_bcd[3:0] > 4'd9 || out_bcd[7:4] > 4'd9 || out_bcd[11:8] > 4'd2)
        check_eq("sweep_digit_range", 32'(out_bcd), 32'(r));
      tick();
    end
    check_eq("sweep_last", 32'(out_bcd), 32'h255);

    convert_wide("w1023", 10'd1023, 16'h1023);
    convert_wide("w999",  10'd999,  16'h0999);
    convert_wide("w0",    10'd0,    16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
